iter_shifter: RTL
=================

# iter_shifter

Parametrised multi-cycle shifter for the RISC-V execute stage that generalises the fixed single-bit left shift used for branch offsets. It supports variable shift amount and four modes: SLL, SRL, SRA and ROR. It shifts up to STEP bit positions per cycle, which trades latency for area, and uses a start/busy/valid handshake toward the ALU control. Results are held stable in a register until the next operation completes.

## Interface
- WIDTH, 32, datapath width; power of two, ≥ 8
- STEP, 4, maximum bit positions shifted per cycle; power of two, 1..WIDTH
- SHW (localparam), $clog2(WIDTH), width of the shift-amount field
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset; one clock, asynchronous, active-low
- start_i  input  1  request a new operation; accepted only while busy_o=0
- op_i  input  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROR; sampled on accept
- data_i  input  WIDTH  operand; sampled on accept
- shamt_i  input  SHW  shift amount, 0..WIDTH-1; sampled on accept
- flush_i  input  1  synchronous abort of the in-flight operation (pipeline flush)
- busy_o  output  1  high while in SHIFT state
- valid_o  output  1  one-cycle pulse; result_o is new and valid
- result_o  output  WIDTH  last completed result, held until the next completion

## Operation
- States: IDLE, SHIFT, DONE. Internal registers: acc (WIDTH), rem (SHW+1), op, fill bit.
- Accept: when start_i=1, flush_i=0 and state is IDLE or DONE:
  - acc<=data_i, rem<=shamt_i, op<=op_i, fill<=data_i[WIDTH-1]
  - state<=SHIFT
- SHIFT, each cycle: k = min(rem, STEP).
  - SLL shifts acc left by k with zero fill.
  - SRL shifts right by k with zero fill.
  - SRA shifts right by k with fill-bit fill.
  - ROR rotates right by k.
  - If rem > STEP: rem<=rem-STEP, stay in SHIFT.
  - Else: result_o<=shifted value, rem<=0, state<=DONE.
- A rem=0 operation spends exactly one SHIFT cycle with k=0, so result_o=data_i.
- DONE: valid_o=1 for that cycle only. Next state is SHIFT if a start is accepted, else IDLE.
- start_i while busy_o=1 is ignored; it is not queued.
- flush_i=1 in any state:
  - state<=IDLE; no valid_o is produced for the aborted operation
  - result_o is unchanged
  - flush_i overrides a simultaneous start_i, which is dropped
- Inputs are don't-care except in the accept cycle.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE; busy_o=0, valid_o=0, result_o=0; acc, rem, op, fill = 0. An operation in flight when reset asserts is lost.
- busy_o and valid_o are decoded from state registers; they are glitch-free, with no combinational path from inputs.
- Latency from the accept edge to the valid_o cycle is 1 + max(1, ceil(shamt/STEP)) cycles.
  - WIDTH=32, STEP=4: shamt 0 → 2 cycles; shamt 8 → 3; shamt 31 → 9.
- busy_o is high for max(1, ceil(shamt/STEP)) cycles, starting the cycle after accept.
- Throughput: a start accepted in the DONE cycle begins SHIFT on the next edge. There are no idle bubbles between back-to-back operations.
- result_o changes only on the edge that enters DONE.

## Test plan
- SLL, data 0x0000_0001, shamt 1 (the branch-offset case) → result_o=0x0000_0002; valid_o pulses exactly 2 cycles after accept; busy_o high 1 cycle.
- SRA, data 0x8000_0000, shamt 31 → 0xFFFF_FFFF; valid_o at cycle 9; busy_o high cycles 1–8. SRL with the same inputs → 0x0000_0001.
- ROR, data 0x0000_0001, shamt 4 → 0x1000_0000 at cycle 2. All four ops with shamt 0 and data 0xDEAD_BEEF → result 0xDEAD_BEEF at cycle 2.
- Start pulses during busy_o are ignored, and results match only the accepted operation.
- Flush in SHIFT cycle 3 of a shamt-31 op → no valid_o, result_o keeps its previous value, state returns to IDLE.
- Start held high in the DONE cycle → the second result follows with no gap.
- rst_n driven low mid-SHIFT without a clock edge → busy_o, valid_o and result_o are 0 immediately. Then run WIDTH=8, STEP=1 and WIDTH=64, STEP=8 random regressions against a reference model covering all ops and shamts.

Source files
------------

// File: rtl/iter_shifter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iter_shifter_if : start/busy/valid handshake bundle for iter_shifter
// Revision: 1.0
// ---------------------------------------------------------------------------
interface iter_shifter_if #(
   parameter int WIDTH = 32
);
   localparam int SHW = $clog2(WIDTH);

   logic             start_i;
   logic [1:0]       op_i;
   logic [WIDTH-1:0] data_i;
   logic [SHW-1:0]   shamt_i;
   logic             flush_i;
   logic             busy_o;
   logic             valid_o;
   logic [WIDTH-1:0] result_o;

   modport master (
      output start_i, op_i, data_i, shamt_i, flush_i,
      input  busy_o, valid_o, result_o
   );

   modport slave (
      input  start_i, op_i, data_i, shamt_i, flush_i,
      output busy_o, valid_o, result_o
   );
endinterface
`default_nettype wire

// File: rtl/iter_shifter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iter_shifter : multi-cycle SLL/SRL/SRA/ROR shifter, up to STEP bits per cycle
// Revision: 1.0
// ---------------------------------------------------------------------------
module iter_shifter #(
   parameter int WIDTH = 32,
   parameter int STEP  = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   iter_shifter_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);
   localparam int KW  = $clog2(STEP) + 1;
   localparam logic [SHW:0] c_step  = (SHW+1)'(STEP);
   localparam logic [SHW:0] c_width = (SHW+1)'(WIDTH);

   localparam logic [1:0] c_op_sll = 2'b00;
   localparam logic [1:0] c_op_srl = 2'b01;
   localparam logic [1:0] c_op_sra = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_DONE  = 2'b10
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_acc;
   logic [SHW:0]     r_rem;
   logic [1:0]       r_op;
   logic             r_fill;
   logic [WIDTH-1:0] r_result;

   logic [KW-1:0]    w_k;
   logic [SHW:0]     w_ror_back;
   logic [WIDTH-1:0] w_sll;
   logic [WIDTH-1:0] w_srl;
   logic [WIDTH-1:0] w_sra;
   logic [WIDTH-1:0] w_ror;
   logic [WIDTH-1:0] w_next;
   logic             w_accept;

   // k never exceeds STEP, so the shifter only needs log2(STEP)+1 amount bits
   assign w_k        = (r_rem > c_step) ? c_step[KW-1:0] : r_rem[KW-1:0];
   assign w_ror_back = c_width - (SHW+1)'(w_k);

   assign w_sll = r_acc << w_k;
   assign w_srl = r_acc >> w_k;
   assign w_sra = w_srl | (~({WIDTH{1'b1}} >> w_k) & {WIDTH{r_fill}});
   // k=0 gives a back-shift of WIDTH, which yields zero and leaves acc intact
   assign w_ror = w_srl | (r_acc << w_ror_back);

   always_comb begin
      w_next = w_ror;
      case (r_op)
         c_op_sll: w_next = w_sll;
         c_op_srl: w_next = w_srl;
         c_op_sra: w_next = w_sra;
         default:  w_next = w_ror;
      endcase
   end

   assign w_accept = bus.start_i && !bus.flush_i && (r_state != S_SHIFT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_acc    <= '0;
         r_rem    <= '0;
         r_op     <= 2'b00;
         r_fill   <= 1'b0;
         r_result <= '0;
      end else if (bus.flush_i) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_SHIFT: begin
               r_acc <= w_next;
               if (r_rem > c_step) begin
                  r_rem <= r_rem - c_step;
               end else begin
                  r_rem    <= '0;
                  r_result <= w_next;
                  r_state  <= S_DONE;
               end
            end
            default: begin
               if (w_accept) begin
                  r_acc   <= bus.data_i;
                  r_rem   <= {1'b0, bus.shamt_i};
                  r_op    <= bus.op_i;
                  r_fill  <= bus.data_i[WIDTH-1];
                  r_state <= S_SHIFT;
               end else begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign bus.busy_o   = (r_state == S_SHIFT);
   assign bus.valid_o  = (r_state == S_DONE);
   assign bus.result_o = r_result;

endmodule
`default_nettype wire
